// File: rtl/gpio_pkg.sv
// Shared constants and types for the 32-line APB GPIO block.
package gpio_pkg;

   localparam int unsigned GPIO_W = 32;

   // Register byte offsets (only paddr[7:0] is decoded).
   localparam logic [7:0] ADDR_IN    = 8'h00;
   localparam logic [7:0] ADDR_OUT   = 8'h04;
   localparam logic [7:0] ADDR_OE    = 8'h08;
   localparam logic [7:0] ADDR_INTE  = 8'h0C;
   localparam logic [7:0] ADDR_PTRIG = 8'h10;
   localparam logic [7:0] ADDR_AUX   = 8'h14;
   localparam logic [7:0] ADDR_CTRL  = 8'h18;
   localparam logic [7:0] ADDR_INTS  = 8'h1C;
   localparam logic [7:0] ADDR_ECLK  = 8'h20;
   localparam logic [7:0] ADDR_NEC   = 8'h24;

   // RGPIO_CTRL bit positions.
   localparam int unsigned CTRL_INTE_BIT = 0;
   localparam int unsigned CTRL_INTS_BIT = 1;

   // Software-owned per-line configuration, fanned out to the pad logic.
   typedef struct packed {
      logic [GPIO_W-1:0] out;
      logic [GPIO_W-1:0] oe;
      logic [GPIO_W-1:0] inte;
      logic [GPIO_W-1:0] ptrig;
      logic [GPIO_W-1:0] aux;
      logic [GPIO_W-1:0] eclk;
      logic [GPIO_W-1:0] nec;
   } gpio_cfg_t;

endpackage

// File: rtl/gpio_apb_regs.sv
// APB decode, register file and read mux for the GPIO block.
module gpio_apb_regs
   import gpio_pkg::*;
(
   input  logic              pclk,
   input  logic              preset,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [7:0]        paddr,
   input  logic [GPIO_W-1:0] pwdata,
   input  logic [GPIO_W-1:0] rgpio_in,
   input  logic [GPIO_W-1:0] ints_set,
   output logic              pready,
   output logic [GPIO_W-1:0] prdata,
   output gpio_cfg_t         cfg,
   output logic              ctrl_inte,
   output logic [GPIO_W-1:0] ints
);

   gpio_cfg_t         cfg_d, cfg_q;
   logic              ctrl_inte_d, ctrl_inte_q;
   logic              ctrl_ints_d, ctrl_ints_q;
   logic [GPIO_W-1:0] ints_d, ints_q;
   logic              wr_en;

   assign pready    = psel & penable;
   assign cfg       = cfg_q;
   assign ctrl_inte = ctrl_inte_q;
   assign ints      = ints_q;

   // Register updates; a hardware event overrides a same-cycle INTS/CTRL write.
   always_comb begin
      wr_en       = psel & penable & pwrite;
      cfg_d       = cfg_q;
      ctrl_inte_d = ctrl_inte_q;
      ctrl_ints_d = ctrl_ints_q;
      ints_d      = ints_q;
      if (wr_en) begin
         case (paddr)
            ADDR_OUT:   cfg_d.out   = pwdata;
            ADDR_OE:    cfg_d.oe    = pwdata;
            ADDR_INTE:  cfg_d.inte  = pwdata;
            ADDR_PTRIG: cfg_d.ptrig = pwdata;
            ADDR_AUX:   cfg_d.aux   = pwdata;
            ADDR_CTRL: begin
               ctrl_inte_d = pwdata[CTRL_INTE_BIT];
               ctrl_ints_d = pwdata[CTRL_INTS_BIT];
            end
            ADDR_INTS:  ints_d      = pwdata;
            ADDR_ECLK:  cfg_d.eclk  = pwdata;
            ADDR_NEC:   cfg_d.nec   = pwdata;
            default:    ;
         endcase
      end
      ints_d = ints_d | ints_set;
      if (|ints_set) ctrl_ints_d = 1'b1;
   end

   // Read mux, only live during an APB read.
   always_comb begin
      prdata = '0;
      if (psel && !pwrite) begin
         case (paddr)
            ADDR_IN:    prdata = rgpio_in;
            ADDR_OUT:   prdata = cfg_q.out;
            ADDR_OE:    prdata = cfg_q.oe;
            ADDR_INTE:  prdata = cfg_q.inte;
            ADDR_PTRIG: prdata = cfg_q.ptrig;
            ADDR_AUX:   prdata = cfg_q.aux;
            ADDR_CTRL: begin
               prdata[CTRL_INTE_BIT] = ctrl_inte_q;
               prdata[CTRL_INTS_BIT] = ctrl_ints_q;
            end
            ADDR_INTS:  prdata = ints_q;
            ADDR_ECLK:  prdata = cfg_q.eclk;
            ADDR_NEC:   prdata = cfg_q.nec;
            default:    prdata = '0;
         endcase
      end
   end

   // Register file state.
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         cfg_q       <= '0;
         ctrl_inte_q <= 1'b0;
         ctrl_ints_q <= 1'b0;
         ints_q      <= '0;
      end else begin
         cfg_q       <= cfg_d;
         ctrl_inte_q <= ctrl_inte_d;
         ctrl_ints_q <= ctrl_ints_d;
         ints_q      <= ints_d;
      end
   end

endmodule

// File: rtl/gpio_top.sv
// 32-line APB GPIO: pad drive, input sampling, external strobe and interrupts.
module gpio_top
   import gpio_pkg::*;
(
   input  logic              pclk,
   input  logic              preset,
   input  logic              ext_clk_pad_i,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [31:0]       paddr,
   input  logic [GPIO_W-1:0] pwdata,
   input  logic [GPIO_W-1:0] aux_in,
   output logic              pready,
   output logic [GPIO_W-1:0] prdata,
   output logic              IRQ,
   inout  wire  [GPIO_W-1:0] io_pad
);

   gpio_cfg_t         cfg;
   logic              ctrl_inte;
   logic [GPIO_W-1:0] ints;
   logic [GPIO_W-1:0] pad_out;
   logic [GPIO_W-1:0] pad_s1_d, pad_s1_q, pad_s2_d, pad_s2_q;
   logic [GPIO_W-1:0] in_d, in_q, in_prev_d, in_prev_q;
   logic [GPIO_W-1:0] load, evt;
   logic [2:0]        ext_d, ext_q;
   logic              ext_rise, ext_fall;
   logic              irq_d, irq_q;
   logic [23:0]       unused_paddr;

   assign unused_paddr = paddr[31:8];
   assign IRQ          = irq_q;

   gpio_apb_regs u_regs (
      .pclk      (pclk),
      .preset    (preset),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr[7:0]),
      .pwdata    (pwdata),
      .rgpio_in  (in_q),
      .ints_set  (evt),
      .pready    (pready),
      .prdata    (prdata),
      .cfg       (cfg),
      .ctrl_inte (ctrl_inte),
      .ints      (ints)
   );

   // Per-line output source select.
   always_comb pad_out = (aux_in & cfg.aux) | (cfg.out & ~cfg.aux);

   for (genvar i = 0; i < GPIO_W; i++) begin : g_pad
      assign io_pad[i] = cfg.oe[i] ? pad_out[i] : 1'bz;
   end

   // Synchronizers, RGPIO_IN load selection and edge-event detection.
   always_comb begin
      pad_s1_d  = io_pad;
      pad_s2_d  = pad_s1_q;
      // ext_q[0]/[1] synchronize, ext_q[2] is the one-cycle delay for edge detect
      ext_d     = {ext_q[1:0], ext_clk_pad_i};
      ext_rise  = ext_q[1] & ~ext_q[2];
      ext_fall  = ~ext_q[1] & ext_q[2];
      load      = ~cfg.eclk | (~cfg.nec & {GPIO_W{ext_rise}})
                            | (cfg.nec & {GPIO_W{ext_fall}});
      in_d      = (load & pad_s2_q) | (~load & in_q);
      in_prev_d = in_q;
      evt       = cfg.inte & ((in_q & ~in_prev_q & cfg.ptrig)
                            | (~in_q & in_prev_q & ~cfg.ptrig));
      irq_d     = ctrl_inte & (|ints);
   end

   // Sampling and interrupt state.
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         pad_s1_q  <= '0;
         pad_s2_q  <= '0;
         ext_q     <= '0;
         in_q      <= '0;
         in_prev_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         pad_s1_q  <= pad_s1_d;
         pad_s2_q  <= pad_s2_d;
         ext_q     <= ext_d;
         in_q      <= in_d;
         in_prev_q <= in_prev_d;
         irq_q     <= irq_d;
      end
   end

endmodule

// File: tb/tb_gpio_top.sv
// Directed plus randomized bench for gpio_top with a register/interrupt model.
module tb_gpio_top;
   import gpio_pkg::*;

   logic        pclk = 1'b0;
   logic        preset = 1'b0;
   logic        ext_clk_pad_i = 1'b0;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0] paddr = '0, pwdata = '0, aux_in = '0;
   logic        pready, IRQ;
   logic [31:0] prdata;
   wire  [31:0] io_pad;
   logic [31:0] tb_oe = '0, tb_val = '0;

   int n_cmp = 0;
   int n_err = 0;

   gpio_top dut (
      .pclk          (pclk),
      .preset        (preset),
      .ext_clk_pad_i (ext_clk_pad_i),
      .psel          (psel),
      .penable       (penable),
      .pwrite        (pwrite),
      .paddr         (paddr),
      .pwdata        (pwdata),
      .aux_in        (aux_in),
      .pready        (pready),
      .prdata        (prdata),
      .IRQ           (IRQ),
      .io_pad        (io_pad)
   );

   for (genvar g = 0; g < 32; g++) begin : g_drv
      assign io_pad[g] = tb_oe[g] ? tb_val[g] : 1'bz;
   end

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // All tasks start and end #1 after a rising edge.
   task automatic tick(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
      psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
      tick(1);
      penable = 1'b1;
      tick(1);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
      psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
      tick(1);
      penable = 1'b1;
      #1 d = prdata;
      tick(1);
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic peek(input logic [31:0] a, output logic [31:0] d);
      psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
      #1 d = prdata;
      psel = 1'b0;
   endtask

   // Expected INTS bits for one stable pad transition old -> new.
   function automatic logic [31:0] exp_events(input logic [31:0] o, input logic [31:0] n,
                                              input logic [31:0] inte, input logic [31:0] ptrig);
      logic [31:0] r;
      for (int i = 0; i < 32; i++)
         r[i] = inte[i] && ((ptrig[i] && !o[i] && n[i]) || (!ptrig[i] && o[i] && !n[i]));
      return r;
   endfunction

   initial begin
      logic [31:0] rd, v, mask, av, old_pad, new_pad, inte, ptrig, ev, hi;
      logic [31:0] model [4];
      logic [7:0]  woff [4];
      int          k;

      woff[0] = ADDR_OUT; woff[1] = ADDR_PTRIG; woff[2] = ADDR_AUX; woff[3] = ADDR_NEC;
      for (int i = 0; i < 4; i++) model[i] = '0;

      // Reset behaviour
      #2;
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h04;
      #1;
      chk("rst_pready", {31'b0, pready}, 32'h1);
      chk("rst_prdata", prdata, 32'h0);
      chk("rst_irq", {31'b0, IRQ}, 32'h0);
      psel = 1'b0; penable = 1'b0;
      #1;
      chk("idle_pready", {31'b0, pready}, 32'h0);
      tick(2);
      preset = 1'b1;
      tick(1);
      for (int a = 4; a <= 'h24; a += 4) begin
         apb_read(a, rd);
         chk($sformatf("rst_reg_%0h", a), rd, 32'h0);
      end

      // Randomized register traffic against a model, including ignored writes
      for (int it = 0; it < 20; it++) begin
         k  = $urandom_range(0, 5);
         v  = $urandom;
         hi = $urandom;
         hi[7:0] = 8'h00;
         if (k < 4) begin
            apb_write(hi | {24'h0, woff[k]}, v);
            model[k] = v;
         end else if (k == 4) begin
            apb_write(hi | {24'h0, ADDR_IN}, v);
         end else begin
            apb_write(hi | 32'h28 | (32'($urandom_range(0, 50)) << 2), v);
         end
         k = $urandom_range(0, 3);
         apb_read({24'h0, woff[k]}, rd);
         chk($sformatf("rand_reg_%0h", woff[k]), rd, model[k]);
      end
      hi = $urandom;
      hi[7:0] = 8'h00;
      apb_read(hi | 32'h40, rd);
      chk("unmapped_read", rd, 32'h0);
      apb_write(ADDR_AUX, 32'h0);

      // Output register readback with partial OE
      apb_write(ADDR_OE, 32'hFFFF0000);
      apb_write(ADDR_OUT, 32'hA5A5A5A5);
      tb_val = 32'h00003C3C; tb_oe = 32'h0000FFFF;
      tick(1);
      chk("pad_hi_drive", {16'h0, io_pad[31:16]}, 32'h0000A5A5);
      chk("pad_lo_released", {16'h0, io_pad[15:0]}, 32'h00003C3C);
      apb_read(ADDR_OUT, rd);
      chk("out_readback", rd, 32'hA5A5A5A5);

      // AUX override
      tb_oe = '0;
      apb_write(ADDR_OE, 32'hFFFFFFFF);
      apb_write(ADDR_AUX, 32'hFFFFFFFF);
      aux_in = 32'hF0F0F0F0;
      tick(1);
      chk("aux_full", io_pad, 32'hF0F0F0F0);
      mask = $urandom; av = $urandom;
      apb_write(ADDR_AUX, mask);
      aux_in = av;
      tick(1);
      chk("aux_mixed", io_pad, (av & mask) | (32'hA5A5A5A5 & ~mask));
      apb_write(ADDR_AUX, 32'h0);
      tick(1);
      chk("aux_off", io_pad, 32'hA5A5A5A5);

      // Input sampling latency
      apb_write(ADDR_OE, 32'h0);
      tb_val = 32'h0; tb_oe = 32'hFFFFFFFF;
      tick(6);
      tb_val = 32'h12345678;
      tick(2);
      peek(ADDR_IN, rd);
      chk("in_lat2_old", rd, 32'h0);
      tick(1);
      peek(ADDR_IN, rd);
      chk("in_lat3_new", rd, 32'h12345678);
      tb_oe = 32'h0000FFFF; tb_val = 32'h0000BEEF;
      tick(4);
      apb_read(ADDR_IN, rd);
      chk("in_partial", {16'h0, rd[15:0]}, 32'h0000BEEF);
      chk("in_xfree", {31'b0, $isunknown(rd[15:0])}, 32'h0);
      tb_oe = 32'hFFFFFFFF; tb_val = 32'h12345678;
      tick(6);

      // Rising-edge interrupt
      apb_write(ADDR_INTE, 32'hFF);
      apb_write(ADDR_PTRIG, 32'hFF);
      apb_write(ADDR_CTRL, 32'h1);
      tb_val = 32'h00000001;
      tick(4);
      chk("irq_lat4", {31'b0, IRQ}, 32'h0);
      tick(1);
      chk("irq_lat5", {31'b0, IRQ}, 32'h1);
      apb_read(ADDR_INTS, rd);
      chk("ints_bit0", rd, 32'h1);
      apb_read(ADDR_CTRL, rd);
      chk("ctrl_ints_set", rd, 32'h3);
      apb_write(ADDR_INTS, 32'h0);
      tick(1);
      chk("irq_cleared", {31'b0, IRQ}, 32'h0);
      tb_val = 32'h00000003;
      tick(6);
      apb_read(ADDR_INTS, rd);
      chk("ints_bit1", rd, 32'h2);
      apb_write(ADDR_INTS, 32'h0);
      apb_read(ADDR_INTS, rd);
      chk("ints_clear", rd, 32'h0);

      // Randomized edge/polarity interrupts against the event model
      apb_write(ADDR_CTRL, 32'h1);
      old_pad = 32'h00000003;
      for (int it = 0; it < 12; it++) begin
         inte = $urandom; ptrig = $urandom; new_pad = $urandom;
         apb_write(ADDR_INTE, inte);
         apb_write(ADDR_PTRIG, ptrig);
         tb_val = new_pad;
         tick(6);
         ev = exp_events(old_pad, new_pad, inte, ptrig);
         apb_read(ADDR_INTS, rd);
         chk($sformatf("rand_ints_%0d", it), rd, ev);
         chk($sformatf("rand_irq_%0d", it), {31'b0, IRQ}, {31'b0, |ev});
         apb_read(ADDR_CTRL, rd);
         chk($sformatf("rand_ctrl_%0d", it), rd, {30'b0, |ev, 1'b1});
         apb_write(ADDR_INTS, 32'h0);
         apb_write(ADDR_CTRL, 32'h1);
         old_pad = new_pad;
      end

      // External-clock sampling
      apb_write(ADDR_INTE, 32'h0);
      apb_write(ADDR_ECLK, 32'hFFFFFFFF);
      apb_write(ADDR_NEC, 32'h0);
      tb_val = 32'hCAFEBABE;
      tick(6);
      apb_read(ADDR_IN, rd);
      chk("eclk_hold", rd, old_pad);
      ext_clk_pad_i = 1'b1;
      tick(2);
      peek(ADDR_IN, rd);
      chk("eclk_rise_early", rd, old_pad);
      tick(1);
      peek(ADDR_IN, rd);
      chk("eclk_rise_load", rd, 32'hCAFEBABE);
      apb_write(ADDR_NEC, 32'hFFFFFFFF);
      tb_val = 32'h0BADF00D;
      tick(6);
      apb_read(ADDR_IN, rd);
      chk("nec_hold", rd, 32'hCAFEBABE);
      ext_clk_pad_i = 1'b0;
      tick(5);
      apb_read(ADDR_IN, rd);
      chk("nec_fall_load", rd, 32'h0BADF00D);
      tb_val = 32'h13579BDF;
      ext_clk_pad_i = 1'b1;
      tick(5);
      apb_read(ADDR_IN, rd);
      chk("nec_rise_ignored", rd, 32'h0BADF00D);
      apb_write(ADDR_ECLK, 32'h0);
      apb_write(ADDR_NEC, 32'h0);
      tick(4);

      // Collision: INTS=0 write committing on the edge that latches an event
      apb_write(ADDR_INTE, 32'h1);
      apb_write(ADDR_PTRIG, 32'h1);
      tb_val = 32'h13579BDE;
      tick(6);
      apb_write(ADDR_INTS, 32'h0);
      apb_write(ADDR_CTRL, 32'h1);
      apb_read(ADDR_INTS, rd);
      chk("coll_pre_clear", rd, 32'h0);
      tb_val = 32'h13579BDF;
      tick(2);
      apb_write(ADDR_INTS, 32'h0);
      apb_read(ADDR_INTS, rd);
      chk("coll_event_wins", rd, 32'h1);
      chk("coll_irq", {31'b0, IRQ}, 32'h1);

      // Reset asserted in the access phase of a write
      psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = ADDR_OUT; pwdata = 32'hFFFFFFFF;
      tick(1);
      penable = 1'b1;
      #2 preset = 1'b0;
      #1;
      chk("midrst_irq", {31'b0, IRQ}, 32'h0);
      chk("midrst_pready", {31'b0, pready}, 32'h1);
      tick(1);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      tick(2);
      preset = 1'b1;
      tick(1);
      for (int a = 4; a <= 'h24; a += 4) begin
         apb_read(a, rd);
         chk($sformatf("midrst_reg_%0h", a), rd, 32'h0);
      end
      chk("midrst_irq_after", {31'b0, IRQ}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
